bus_xfer_sequencer: RTL
=======================

Name: bus_xfer_sequencer

Overview:
- Control-side counterpart of the datapath Bus.
- Takes a register-transfer request as binary source/destination codes.
- Decodes the source code into the one-hot source-enable vector that feeds the Bus encoder input.
- After the bus settles, decodes the destination code into a one-hot register-load enable for exactly one cycle.
- Sits between the control unit and the Bus/register-file load enables.

Parameters:
- DRIVE_CYCLES, 1, number of cycles the source is driven before the destination latch cycle (legal range 1..7).

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  asynchronous, active-low reset.
- req_valid  in  1  transfer request valid.
- req_ready  out  1  block can accept a request.
- req_src  in  5  source code: 0-15 R0-R15, 16 HI, 17 LO, 18 ZHI, 19 ZLO, 20 PC, 21 MDR, 22 INPORT, 23 CSIGN.
- req_dst  in  5  destination code: 0-15 R0-R15, 16 HI, 17 LO, 20 PC, 21 MDR, 24 MAR, 25 OUTPORT, 26 Y, 27 IR.
- bus_out_en  out  32  one-hot source enable, connects to Bus encIn.
- reg_in_en  out  32  one-hot destination load enable.
- done  out  1  one-cycle pulse when a transfer completes.
- err  out  1  one-cycle pulse when a request is rejected.

Behaviour:
- Reset: clear=0 asynchronously forces state IDLE, drive counter 0, req_ready=1, bus_out_en=0, reg_in_en=0, done=0, err=0.
  - A mid-transfer reset aborts the transfer; no reg_in_en pulse is produced.
- Handshake: a request is accepted on a rising edge where req_valid=1 and req_ready=1.
  - req_src and req_dst are captured at acceptance; later input changes are ignored.
- Legality check, applied at acceptance:
  - Illegal src: any code above 23.
  - Illegal dst: 18, 19, 22, 23, 28-31.
- State machine:
  - IDLE: req_ready=1, all outputs 0.
    - Accept with an illegal code → ERR.
    - Accept with legal codes → DRIVE, counter loaded with DRIVE_CYCLES-1.
  - DRIVE: bus_out_en = 1<<src, reg_in_en = 0, req_ready = 0.
    - Counter decrements each cycle; at 0 → LATCH.
  - LATCH: bus_out_en stays 1<<src (the bus must stay stable while the load occurs), reg_in_en = 1<<dst for exactly this cycle → DONE.
  - DONE: done=1, both enable vectors 0, → IDLE.
  - ERR: err=1, both enable vectors 0, → IDLE.
- Latency: accept at edge N.
  - bus_out_en is valid in cycles N+1 .. N+DRIVE_CYCLES+1.
  - reg_in_en is valid in cycle N+DRIVE_CYCLES+1.
  - done is high in cycle N+DRIVE_CYCLES+2.
  - Back-to-back throughput is one transfer per DRIVE_CYCLES+3 cycles.
- Invariants:
  - bus_out_en and reg_in_en are each either zero or exactly one-hot.
  - reg_in_en is never nonzero unless bus_out_en is nonzero in the same cycle.
- src code equal to dst code is legal (register reload through the bus).
- All outputs are registered; no combinational path from req_* to bus_out_en or reg_in_en.

Optional Feature:
- Macro: BUS_XFER_BACK2BACK_EN.
- Defined:
  - req_ready is also 1 in DONE.
  - A request accepted in DONE goes straight to DRIVE (or ERR), bypassing IDLE.
  - done still pulses in that cycle.
  - Throughput becomes one transfer per DRIVE_CYCLES+2 cycles.
- Undefined: req_ready=1 only in IDLE, as specified in Behaviour.

Decomposition:
- Shared package bus_pkg holds:
  - the source code constants (SRC_R0..SRC_CSIGN = 0..23);
  - the destination code constants (DST_R0..DST_IR);
  - the state encoding (IDLE, DRIVE, LATCH, DONE, ERR);
  - the legality functions src_legal() and dst_legal().
- Sub-module onehot_decoder: 5-bit code plus enable in, 32-bit one-hot out, registered. Instantiated twice, once for the source and once for the destination.

Test Plan:
- Reset, then req src=3 dst=7 with DRIVE_CYCLES=1 → bus_out_en=32'h8 for 2 cycles; reg_in_en=32'h80 in the 2nd of those cycles; done one cycle later; req_ready low throughout.
- src=21 (MDR) dst=27 (IR) with DRIVE_CYCLES=3 → bus_out_en=32'h0020_0000 for 4 cycles; reg_in_en=32'h0800_0000 only in the 4th cycle.
- src=24 or dst=19 → err pulse one cycle after acceptance; both vectors stay 0; req_ready returns to 1 the cycle after.
- clear asserted during DRIVE → all outputs 0 immediately; no reg_in_en pulse; the next request starts cleanly.
- req_valid held high with 3 queued requests → exactly 3 done pulses at a spacing of DRIVE_CYCLES+3 cycles (DRIVE_CYCLES+2 with BUS_XFER_BACK2BACK_EN).
- Random legal codes for 1000 transfers → scoreboard checks the one-hot invariants, src/dst mapping, and that reg_in_en overlaps bus_out_en.

Source files
------------

// File: rtl/bus_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : bus_pkg                                                        |
// | Purpose : Shared definitions for the bus transfer sequencer: source and  |
// |           destination register codes, FSM state encoding, and the code   |
// |           legality helpers used at request acceptance.                   |
// | Ports   : none (package)                                                 |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package bus_pkg;

    localparam int CODE_W = 5;
    localparam int VEC_W  = 32;

    // Source codes (drivers of the bus)
    localparam logic [4:0] SRC_R0  = 5'd0,  SRC_R1  = 5'd1,  SRC_R2  = 5'd2,  SRC_R3  = 5'd3;
    localparam logic [4:0] SRC_R4  = 5'd4,  SRC_R5  = 5'd5,  SRC_R6  = 5'd6,  SRC_R7  = 5'd7;
    localparam logic [4:0] SRC_R8  = 5'd8,  SRC_R9  = 5'd9,  SRC_R10 = 5'd10, SRC_R11 = 5'd11;
    localparam logic [4:0] SRC_R12 = 5'd12, SRC_R13 = 5'd13, SRC_R14 = 5'd14, SRC_R15 = 5'd15;
    localparam logic [4:0] SRC_HI  = 5'd16, SRC_LO  = 5'd17, SRC_ZHI = 5'd18, SRC_ZLO = 5'd19;
    localparam logic [4:0] SRC_PC  = 5'd20, SRC_MDR = 5'd21, SRC_INPORT = 5'd22, SRC_CSIGN = 5'd23;

    // Destination codes (registers loaded from the bus)
    localparam logic [4:0] DST_R0  = 5'd0,  DST_R1  = 5'd1,  DST_R2  = 5'd2,  DST_R3  = 5'd3;
    localparam logic [4:0] DST_R4  = 5'd4,  DST_R5  = 5'd5,  DST_R6  = 5'd6,  DST_R7  = 5'd7;
    localparam logic [4:0] DST_R8  = 5'd8,  DST_R9  = 5'd9,  DST_R10 = 5'd10, DST_R11 = 5'd11;
    localparam logic [4:0] DST_R12 = 5'd12, DST_R13 = 5'd13, DST_R14 = 5'd14, DST_R15 = 5'd15;
    localparam logic [4:0] DST_HI  = 5'd16, DST_LO  = 5'd17, DST_PC  = 5'd20, DST_MDR = 5'd21;
    localparam logic [4:0] DST_MAR = 5'd24, DST_OUTPORT = 5'd25, DST_Y = 5'd26, DST_IR = 5'd27;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRIVE = 3'd1,
        LATCH = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

    function automatic logic src_legal(input logic [4:0] code);
        return code <= SRC_CSIGN;
    endfunction

    // Codes 18/19/22/23 are read-only sources; 28..31 are unassigned.
    function automatic logic dst_legal(input logic [4:0] code);
        return !(code inside {5'd18, 5'd19, 5'd22, 5'd23}) && (code <= DST_IR);
    endfunction

endpackage : bus_pkg
`default_nettype wire

// File: rtl/onehot_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : onehot_decoder                                                 |
// | Purpose : Registered binary-to-one-hot decoder. When en is high the      |
// |           output register loads 1<<code on the next edge, else zero.     |
// | Ports   : clock  - rising-edge clock                                     |
// |           clear  - asynchronous active-low reset                         |
// |           en     - decode enable                                         |
// |           code   - binary code to decode                                 |
// |           onehot - registered one-hot (or zero) vector                   |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module onehot_decoder
    import bus_pkg::*;
(
    input  logic              clock,
    input  logic              clear,
    input  logic              en,
    input  logic [CODE_W-1:0] code,
    output logic [VEC_W-1:0]  onehot
);

    logic [VEC_W-1:0] onehot_d;
    logic [VEC_W-1:0] onehot_q;

    always_comb begin
        onehot_d = '0;
        if (en) begin
            onehot_d[code] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            onehot_q <= '0;
        end else begin
            onehot_q <= onehot_d;
        end
    end

    assign onehot = onehot_q;

endmodule : onehot_decoder
`default_nettype wire

// File: rtl/bus_xfer_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : bus_xfer_sequencer                                             |
// | Purpose : Sequences one register-to-register bus transfer: drives the    |
// |           one-hot source enable for DRIVE_CYCLES cycles, then holds it   |
// |           for one more cycle while pulsing the one-hot destination load. |
// |           Illegal codes are rejected with a one-cycle err pulse.         |
// | Ports   : clock, clear(async, active-low)                                |
// |           req_valid/req_ready/req_src/req_dst - request handshake        |
// |           bus_out_en - one-hot source enable to the bus encoder          |
// |           reg_in_en  - one-hot destination register load enable         |
// |           done / err - one-cycle completion / rejection pulses          |
// | Params  : DRIVE_CYCLES (1..7) cycles of source drive before the load     |
// | Macro   : BUS_XFER_BACK2BACK_EN - accept a new request in the DONE cycle |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module bus_xfer_sequencer
    import bus_pkg::*;
#(
    parameter int DRIVE_CYCLES = 1
)
(
    input  logic              clock,
    input  logic              clear,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [CODE_W-1:0] req_src,
    input  logic [CODE_W-1:0] req_dst,
    output logic [VEC_W-1:0]  bus_out_en,
    output logic [VEC_W-1:0]  reg_in_en,
    output logic              done,
    output logic              err
);

    localparam logic [2:0] CNT_INIT = 3'(DRIVE_CYCLES - 1);

    state_t            state_q, state_d;
    logic [2:0]        cnt_q,   cnt_d;
    logic [CODE_W-1:0] src_q,   src_d;
    logic [CODE_W-1:0] dst_q,   dst_d;
    logic              ready_q, ready_d;
    logic              done_q,  done_d;
    logic              err_q,   err_d;
    logic              accept;

    // ready_q is only ever high in states that may take a request.
    assign accept = req_valid && ready_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        dst_d   = dst_q;

        unique case (state_q)
            IDLE:    state_d = IDLE;
            DRIVE: begin
                if (cnt_q == 3'd0) begin
                    state_d = LATCH;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            LATCH:   state_d = DONE;
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Acceptance overrides the idle/done return path.
        if (accept) begin
            src_d = req_src;
            dst_d = req_dst;
            if (src_legal(req_src) && dst_legal(req_dst)) begin
                state_d = DRIVE;
                cnt_d   = CNT_INIT;
            end else begin
                state_d = ERR;
            end
        end

        // All outputs are registered from the next state so they line up
        // with the state they describe.
        done_d = (state_d == DONE);
        err_d  = (state_d == ERR);
`ifdef BUS_XFER_BACK2BACK_EN
        ready_d = (state_d == IDLE) || (state_d == DONE);
`else
        ready_d = (state_d == IDLE);
`endif
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            src_q   <= '0;
            dst_q   <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Source stays on the bus through LATCH so the load sees a stable value.
    onehot_decoder u_src_dec (
        .clock  (clock),
        .clear  (clear),
        .en     ((state_d == DRIVE) || (state_d == LATCH)),
        .code   (src_d),
        .onehot (bus_out_en)
    );

    onehot_decoder u_dst_dec (
        .clock  (clock),
        .clear  (clear),
        .en     (state_d == LATCH),
        .code   (dst_d),
        .onehot (reg_in_en)
    );

    assign req_ready = ready_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule : bus_xfer_sequencer
`default_nettype wire
